// File: rtl/text_pkg.sv
// Constants shared by the text-mode command engine and the renderer:
// register map, command codes, screen geometry and STATUS bit layout.
package text_pkg;

  localparam logic [14:0] BASE_ADDR = 15'h40F0;

  localparam logic [2:0] OFF_CMD  = 3'd0;
  localparam logic [2:0] OFF_ARG1 = 3'd1;
  localparam logic [2:0] OFF_ARG2 = 3'd2;
  localparam logic [2:0] OFF_ARG3 = 3'd3;
  localparam logic [2:0] OFF_ARG4 = 3'd4;
  localparam logic [2:0] OFF_PAGE = 3'd5;

  localparam logic [7:0] CMD_SET_CHAR    = 8'd0;
  localparam logic [7:0] CMD_APPEND_CHAR = 8'd1;
  localparam logic [7:0] CMD_SET_CURSOR  = 8'd2;
  localparam logic [7:0] CMD_CLEAR       = 8'd3;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS * ROWS;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_ERROR_BIT   = 1;
  localparam int STATUS_OVERRUN_BIT = 2;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FILL} state_t;

  // row*80 + col without a multiplier: 80 = 64 + 16.
  function automatic logic [11:0] cell_index(input logic [7:0] row, input logic [7:0] col);
    logic [11:0] r;
    r = {4'b0, row};
    return (r << 6) + (r << 4) + {4'b0, col};
  endfunction

  function automatic logic coord_ok(input logic [7:0] row, input logic [7:0] col);
    return (col < 8'(COLS)) && (row < 8'(ROWS));
  endfunction

endpackage

// File: rtl/text_cmd_regs.sv
// CPU bus decode for the text window: argument/page registers, STATUS
// with sticky overrun, registered read mux and command-issue qualification.
module text_cmd_regs
  import text_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cs_i,
  input  logic        rw_i,
  input  logic [14:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        busy_i,
  input  logic        engine_busy_i,
  input  logic        error_i,
  output logic [7:0]  data_o,
  output logic        cmd_accept_o,
  output logic [7:0]  cmd_code_o,
  output logic [7:0]  arg1_o,
  output logic [7:0]  arg2_o,
  output logic [7:0]  arg3_o,
  output logic [7:0]  page_o
);
  logic       hit, wr, rd, cmd_wr;
  logic [2:0] off;
  logic [7:0] arg1_q, arg2_q, arg3_q, arg4_q, page_q, data_q;
  logic [7:0] status, rdata;
  logic       overrun_q;

  assign hit    = cs_i && (addr_i[14:3] == BASE_ADDR[14:3]);
  assign off    = addr_i[2:0];
  assign wr     = hit && !rw_i;
  assign rd     = hit && rw_i;
  assign cmd_wr = wr && (off == OFF_CMD);

  assign cmd_accept_o = cmd_wr && !engine_busy_i;
  assign cmd_code_o   = data_i;
  assign arg1_o       = arg1_q;
  assign arg2_o       = arg2_q;
  assign arg3_o       = arg3_q;
  assign page_o       = page_q;
  assign data_o       = data_q;

  always_comb begin
    status = '0;
    status[STATUS_BUSY_BIT]    = busy_i;
    status[STATUS_ERROR_BIT]   = error_i;
    status[STATUS_OVERRUN_BIT] = overrun_q;
    rdata = '0;
    case (off)
      OFF_CMD:  rdata = status;
      OFF_ARG1: rdata = arg1_q;
      OFF_ARG2: rdata = arg2_q;
      OFF_ARG3: rdata = arg3_q;
      OFF_ARG4: rdata = arg4_q;
      OFF_PAGE: rdata = page_q;
      default:  rdata = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      arg1_q    <= '0;
      arg2_q    <= '0;
      arg3_q    <= '0;
      arg4_q    <= '0;
      page_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr) begin
        case (off)
          OFF_ARG1: arg1_q <= data_i;
          OFF_ARG2: arg2_q <= data_i;
          OFF_ARG3: arg3_q <= data_i;
          OFF_ARG4: arg4_q <= data_i;
          OFF_PAGE: page_q <= data_i;
          default:  ;
        endcase
      end
      if (rd) data_q <= rdata;
      // A rejected command outranks a simultaneous STATUS read clear.
      if (cmd_wr && engine_busy_i)    overrun_q <= 1'b1;
      else if (rd && off == OFF_CMD)  overrun_q <= 1'b0;
    end
  end

endmodule

// File: rtl/text_cmd_engine.sv
// Text buffer writer: latches accepted commands, runs the IDLE/EXEC/FILL
// sequencer, owns the cursor and drives one buffer write per clock.
module text_cmd_engine
  import text_pkg::*;
(
  input  logic        cpu_clock,
  input  logic        reset,
  input  logic        cs,
  input  logic        rw,
  input  logic [14:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        buf_we,
  output logic [11:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic        busy,
  output logic [11:0] cursor_pos,
  output logic [7:0]  page_sel
);
  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  sh_arg1_q, sh_arg1_d, sh_arg2_q, sh_arg2_d, sh_arg3_q, sh_arg3_d;
  logic        error_q, error_d;
  logic [11:0] cursor_q, cursor_d;
  logic        we_q, we_d;
  logic [11:0] waddr_q, waddr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        cmd_accept, engine_busy, in_range;
  logic [7:0]  cmd_code, arg1, arg2, arg3;
  logic [11:0] target;

  // A latched-but-not-started command also blocks new issues.
  assign busy        = (state_q != S_IDLE);
  assign engine_busy = busy || pend_q;
  assign in_range    = coord_ok(sh_arg3_q, sh_arg2_q);
  assign target      = cell_index(sh_arg3_q, sh_arg2_q);

  assign buf_we     = we_q;
  assign buf_addr   = waddr_q;
  assign buf_data   = wdata_q;
  assign cursor_pos = cursor_q;

  text_cmd_regs u_regs (
    .clk_i         (cpu_clock),
    .reset_i       (reset),
    .cs_i          (cs),
    .rw_i          (rw),
    .addr_i        (addr),
    .data_i        (data_in),
    .busy_i        (busy),
    .engine_busy_i (engine_busy),
    .error_i       (error_q),
    .data_o        (data_out),
    .cmd_accept_o  (cmd_accept),
    .cmd_code_o    (cmd_code),
    .arg1_o        (arg1),
    .arg2_o        (arg2),
    .arg3_o        (arg3),
    .page_o        (page_sel)
  );

  // NOTE: every _d starts from a default so no path leaves it unassigned
  // (otherwise a latch is inferred).
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cmd_d     = cmd_q;
    sh_arg1_d = sh_arg1_q;
    sh_arg2_d = sh_arg2_q;
    sh_arg3_d = sh_arg3_q;
    error_d   = error_q;
    cursor_d  = cursor_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;

    if (cmd_accept) begin
      pend_d    = 1'b1;
      cmd_d     = cmd_code;
      sh_arg1_d = arg1;
      sh_arg2_d = arg2;
      sh_arg3_d = arg3;
      error_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = S_EXEC;
          case (cmd_q)
            CMD_SET_CHAR: begin
              if (in_range) begin
                we_d    = 1'b1;
                waddr_d = target;
                wdata_d = sh_arg1_q;
              end else begin
                error_d = 1'b1;
              end
            end
            CMD_APPEND_CHAR: begin
              we_d     = 1'b1;
              waddr_d  = cursor_q;
              wdata_d  = sh_arg1_q;
              cursor_d = (cursor_q == 12'(CELLS - 1)) ? '0 : cursor_q + 12'd1;
            end
            CMD_SET_CURSOR: begin
              if (in_range) cursor_d = target;
              else          error_d  = 1'b1;
            end
            CMD_CLEAR: begin
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = sh_arg1_q;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        if (cmd_q == CMD_CLEAR) begin
          state_d = S_FILL;
          we_d    = 1'b1;
          waddr_d = waddr_q + 12'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (waddr_q == 12'(CELLS - 1)) begin
          state_d  = S_IDLE;
          cursor_d = '0;
        end else begin
          we_d    = 1'b1;
          waddr_d = waddr_q + 12'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      cmd_q     <= '0;
      sh_arg1_q <= '0;
      sh_arg2_q <= '0;
      sh_arg3_q <= '0;
      error_q   <= 1'b0;
      cursor_q  <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      cmd_q     <= cmd_d;
      sh_arg1_q <= sh_arg1_d;
      sh_arg2_q <= sh_arg2_d;
      sh_arg3_q <= sh_arg3_d;
      error_q   <= error_d;
      cursor_q  <= cursor_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

endmodule

// File: tb/tb_text_cmd_engine.sv
// Scoreboard bench for text_cmd_engine: stimulus queues expected buffer
// writes and read data; a negedge monitor pops and compares them.
module tb_text_cmd_engine;
  import text_pkg::*;

  logic        cpu_clock = 1'b0;
  logic        reset     = 1'b1;
  logic        cs        = 1'b0;
  logic        rw        = 1'b0;
  logic [14:0] addr      = '0;
  logic [7:0]  data_in   = '0;
  logic [7:0]  data_out;
  logic        buf_we;
  logic [11:0] buf_addr;
  logic [7:0]  buf_data;
  logic        busy;
  logic [11:0] cursor_pos;
  logic [7:0]  page_sel;

  text_cmd_engine dut (
    .cpu_clock  (cpu_clock),
    .reset      (reset),
    .cs         (cs),
    .rw         (rw),
    .addr       (addr),
    .data_in    (data_in),
    .data_out   (data_out),
    .buf_we     (buf_we),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .busy       (busy),
    .cursor_pos (cursor_pos),
    .page_sel   (page_sel)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [2:0] off; logic [7:0] d; } rd_t;

  wr_t  wr_q[$];
  rd_t  rd_q[$];
  wr_t  wr_exp;
  rd_t  rd_exp;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic rd_seen = 1'b0;
  int   cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
  endtask

  always @(posedge cpu_clock) rd_seen <= cs && rw && !reset;

  always @(negedge cpu_clock) begin
    if (buf_we) begin
      check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_exp = wr_q.pop_front();
        check($sformatf("wr_addr(exp %0d)", wr_exp.a), 32'(buf_addr), 32'(wr_exp.a));
        check($sformatf("wr_data@%0d", wr_exp.a), 32'(buf_data), 32'(wr_exp.d));
      end
    end
    if (rd_seen) begin
      check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        rd_exp = rd_q.pop_front();
        check($sformatf("read_off%0d", rd_exp.off), 32'(data_out), 32'(rd_exp.d));
      end
    end
  end

  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = BASE_ADDR + 15'(off); data_in = d;
    tick();
    cs = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, input logic [7:0] want);
    rd_q.push_back('{off, want});
    cs = 1'b1; rw = 1'b1; addr = BASE_ADDR + 15'(off);
    tick();
    cs = 1'b0; rw = 1'b0;
  endtask

  task automatic set_args(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3);
    bus_write(OFF_ARG1, a1);
    bus_write(OFF_ARG2, a2);
    bus_write(OFF_ARG3, a3);
  endtask

  task automatic wait_idle(input string name, input int limit, output int cycles);
    tick();
    cycles = 0;
    while (busy && cycles < limit) begin
      tick();
      cycles++;
    end
    check({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string name, input logic [7:0] code, output int cycles);
    bus_write(OFF_CMD, code);
    wait_idle(name, 3000, cycles);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_buf_we"},     32'(buf_we),     32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_buf_addr"},   32'(buf_addr),   32'd0);
    check({tag, "_buf_data"},   32'(buf_data),   32'd0);
    check({tag, "_cursor_pos"}, 32'(cursor_pos), 32'd0);
    check({tag, "_page_sel"},   32'(page_sel),   32'd0);
    check({tag, "_data_out"},   32'(data_out),   32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // SET_CHAR 'A' at col 5, row 2 -> cell 165; busy for exactly one cycle.
    set_args(8'h41, 8'd5, 8'd2);
    wr_q.push_back('{12'd165, 8'h41});
    bus_write(OFF_CMD, CMD_SET_CHAR);
    check("t1_busy_before", 32'(busy), 32'd0);
    tick();
    check("t1_busy_high", 32'(busy), 32'd1);
    tick();
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_cursor", 32'(cursor_pos), 32'd0);
    bus_read(OFF_CMD, 8'h00);
    bus_read(OFF_ARG2, 8'd5);

    // PAGE, ARG4 readback and an unmapped window offset.
    bus_write(OFF_PAGE, 8'h3C);
    check("page_sel", 32'(page_sel), 32'h3C);
    bus_write(OFF_ARG4, 8'h99);
    bus_read(OFF_ARG4, 8'h99);
    bus_read(OFF_PAGE, 8'h3C);
    bus_read(3'd6, 8'h00);

    // Cursor to last cell, then two appends wrap to cell 0.
    set_args(8'h5A, 8'd79, 8'd29);
    run("t2_setcur", CMD_SET_CURSOR, cyc);
    check("t2_cursor_2399", 32'(cursor_pos), 32'd2399);
    wr_q.push_back('{12'd2399, 8'h5A});
    run("t2_app1", CMD_APPEND_CHAR, cyc);
    check("t2_cursor_wrap", 32'(cursor_pos), 32'd0);
    wr_q.push_back('{12'd0, 8'h5A});
    run("t2_app2", CMD_APPEND_CHAR, cyc);
    check("t2_cursor_1", 32'(cursor_pos), 32'd1);

    // Range errors and an illegal code; a valid command clears error.
    set_args(8'h5A, 8'd80, 8'd2);
    run("t3_badchar", CMD_SET_CHAR, cyc);
    bus_read(OFF_CMD, 8'h02);
    set_args(8'h5A, 8'd10, 8'd0);
    run("t3_cur10", CMD_SET_CURSOR, cyc);
    check("t3_cursor_10", 32'(cursor_pos), 32'd10);
    bus_read(OFF_CMD, 8'h00);
    bus_write(OFF_ARG3, 8'd30);
    run("t3_badcur", CMD_SET_CURSOR, cyc);
    check("t3_cursor_kept", 32'(cursor_pos), 32'd10);
    bus_read(OFF_CMD, 8'h02);
    run("t3_illegal", 8'h07, cyc);
    bus_read(OFF_CMD, 8'h02);

    // Full CLEAR: 2400 consecutive writes, cursor returns to 0.
    bus_write(OFF_ARG1, 8'h20);
    for (int i = 0; i < CELLS; i++) wr_q.push_back('{12'(i), 8'h20});
    run("t4_clear", CMD_CLEAR, cyc);
    check("t4_busy_cycles", 32'(cyc), 32'd2400);
    check("t4_cursor", 32'(cursor_pos), 32'd0);
    check("t4_wr_drained", 32'(wr_q.size()), 32'd0);
    bus_read(OFF_CMD, 8'h00);

    // Command issued mid-CLEAR is dropped and flags overrun.
    set_args(8'h2E, 8'd3, 8'd0);
    for (int i = 0; i < CELLS; i++) wr_q.push_back('{12'(i), 8'h2E});
    bus_write(OFF_CMD, CMD_CLEAR);
    repeat (100) tick();
    bus_write(OFF_ARG1, 8'h77);
    bus_write(OFF_CMD, CMD_SET_CHAR);
    wait_idle("t5_clear", 3000, cyc);
    check("t5_cursor", 32'(cursor_pos), 32'd0);
    check("t5_wr_drained", 32'(wr_q.size()), 32'd0);
    bus_read(OFF_CMD, 8'h04);
    bus_read(OFF_CMD, 8'h00);
    bus_read(OFF_ARG1, 8'h77);

    // Reset after 500 fill writes aborts the CLEAR.
    for (int i = 0; i < 500; i++) wr_q.push_back('{12'(i), 8'h77});
    bus_write(OFF_CMD, CMD_CLEAR);
    repeat (500) @(posedge cpu_clock);
    #1;
    reset = 1'b1;
    tick();
    check_all_zero("t6_abort");
    check("t6_wr_drained", 32'(wr_q.size()), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    set_args(8'h42, 8'd0, 8'd1);
    wr_q.push_back('{12'd80, 8'h42});
    run("t6_setchar", CMD_SET_CHAR, cyc);
    check("t6_cursor", 32'(cursor_pos), 32'd0);
    bus_read(OFF_CMD, 8'h00);

    repeat (3) tick();
    check("end_wr_q_empty", 32'(wr_q.size()), 32'd0);
    check("end_rd_q_empty", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
